// File: rtl/mpfifo_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mpfifo_sched_pkg : shared state encoding and sizing helper for the scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package mpfifo_sched_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_RELOAD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_RUN    = ST_RUN,
        S_RELOAD = ST_RELOAD
    } sched_state_t;

    // Ceiling log2, never less than 1 so a 1-bit field is always legal.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpfifo_rr_multi_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mpfifo_rr_multi_pick : picks up to SLOTS eligible requesters in round-robin
// order starting at rr_ptr and packs them onto ports 0..k-1.  Rev 1.0
// ---------------------------------------------------------------------------
module mpfifo_rr_multi_pick
    import mpfifo_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = clog2(N_REQ),
    parameter int SLOT_W    = clog2(NUM_PORTS + 1)
) (
    input  logic [N_REQ-1:0]                eligible,
    input  logic [PTR_W-1:0]                rr_ptr,
    input  logic [SLOT_W-1:0]               slots,
    output logic [NUM_PORTS-1:0][N_REQ-1:0] port_sel,
    output logic [NUM_PORTS-1:0]            port_valid,
    output logic [N_REQ-1:0]                grant,
    output logic [PTR_W-1:0]                next_ptr
);

    always_comb begin
        int taken;
        int last;
        int idx;
        port_sel   = '0;
        port_valid = '0;
        grant      = '0;
        next_ptr   = rr_ptr;
        taken      = 0;
        last       = 0;
        idx        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            // Constant-index inner loops keep every select statically bounded.
            for (int i = 0; i < N_REQ; i++) begin
                if (i == idx && eligible[i] && taken < int'(slots)) begin
                    grant[i] = 1'b1;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (p == taken) begin
                            port_sel[p][i] = 1'b1;
                            port_valid[p]  = 1'b1;
                        end
                    end
                    taken = taken + 1;
                    last  = i;
                end
            end
        end
        if (taken != 0) begin
            next_ptr = (last + 1 >= N_REQ) ? '0 : PTR_W'(last + 1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mpfifo_write_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mpfifo_write_scheduler : weighted round-robin packer of N_REQ producers onto
// the write ports of multi_ported_fifo.  Rev 1.0
// ---------------------------------------------------------------------------
module mpfifo_write_scheduler
    import mpfifo_sched_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int N_REQ           = 4,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int WEIGHT_W        = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enable,
    input  logic [N_REQ-1:0]                      req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]           req_data,
    output logic [N_REQ-1:0]                      req_ready,
    output logic [NUM_WRITE_PORTS-1:0]            fifo_wr_en,
    output logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] fifo_wr_data,
    input  logic [NUM_WRITE_PORTS-1:0]            fifo_wr_ready,
    input  logic                                  cfg_we,
    input  logic [clog2(N_REQ)-1:0]               cfg_idx,
    input  logic [WEIGHT_W-1:0]                   cfg_weight,
    output logic [1:0]                            state_o,
    output logic [31:0]                           beat_count
);

    localparam int PTR_W  = clog2(N_REQ);
    localparam int SLOT_W = clog2(NUM_WRITE_PORTS + 1);

    sched_state_t                          r_state;
    logic [PTR_W-1:0]                      r_rr_ptr;
    logic [N_REQ-1:0][WEIGHT_W-1:0]        r_weight;
    logic [N_REQ-1:0][WEIGHT_W-1:0]        r_credit;
    logic [31:0]                           r_beat_count;

    logic [SLOT_W-1:0]                     w_slots;
    logic [N_REQ-1:0]                      w_eligible;
    logic                                  w_weighted_valid;
    logic [NUM_WRITE_PORTS-1:0][N_REQ-1:0] w_port_sel;
    logic [NUM_WRITE_PORTS-1:0]            w_port_valid;
    logic [N_REQ-1:0]                      w_grant;
    logic [PTR_W-1:0]                      w_next_ptr;
    logic [31:0]                           w_num_grants;

    // Usable ports are the unbroken run of ready bits from port 0; only RUN grants.
    always_comb begin
        w_slots = '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (fifo_wr_ready[p] && int'(w_slots) == p) begin
                w_slots = SLOT_W'(p + 1);
            end
        end
        if (r_state != S_RUN) begin
            w_slots = '0;
        end
    end

    always_comb begin
        w_eligible       = '0;
        w_weighted_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_eligible[i]    = req_valid[i] && (r_weight[i] != '0) && (r_credit[i] != '0);
            w_weighted_valid = w_weighted_valid || (req_valid[i] && (r_weight[i] != '0));
        end
    end

    mpfifo_rr_multi_pick #(
        .N_REQ     (N_REQ),
        .NUM_PORTS (NUM_WRITE_PORTS),
        .PTR_W     (PTR_W),
        .SLOT_W    (SLOT_W)
    ) u_pick (
        .eligible   (w_eligible),
        .rr_ptr     (r_rr_ptr),
        .slots      (w_slots),
        .port_sel   (w_port_sel),
        .port_valid (w_port_valid),
        .grant      (w_grant),
        .next_ptr   (w_next_ptr)
    );

    always_comb begin
        w_num_grants = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_num_grants = w_num_grants + 32'(w_grant[i]);
        end
    end

    always_comb begin
        fifo_wr_data = '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_port_sel[p][i]) begin
                    fifo_wr_data[p*DATA_WIDTH +: DATA_WIDTH] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign fifo_wr_en = w_port_valid;
    assign req_ready  = w_grant;
    assign state_o    = r_state;
    assign beat_count = r_beat_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_beat_count <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_weight[i] <= WEIGHT_W'(1);
                r_credit[i] <= '0;
            end
        end else begin
            // Reloads below read r_weight, so a same-edge write lands after them.
            for (int i = 0; i < N_REQ; i++) begin
                if (cfg_we && cfg_idx == PTR_W'(i)) begin
                    r_weight[i] <= cfg_weight;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state  <= S_RUN;
                        r_credit <= r_weight;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (w_grant[i]) begin
                            r_credit[i] <= r_credit[i] - 1'b1;
                        end
                    end
                    r_rr_ptr     <= w_next_ptr;
                    r_beat_count <= r_beat_count + w_num_grants;
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (w_weighted_valid && (w_eligible == '0)) begin
                        r_state <= S_RELOAD;
                    end
                end
                S_RELOAD: begin
                    r_credit <= r_weight;
                    r_state  <= enable ? S_RUN : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mpfifo_write_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mpfifo_write_scheduler : directed scenarios plus random traffic against
// a queue-based reference model of the weighted round-robin scheduler.
// ---------------------------------------------------------------------------
module tb_mpfifo_write_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [1:0]   fifo_wr_en;
    logic [63:0]  fifo_wr_data;
    logic [1:0]   fifo_wr_ready;
    logic         cfg_we;
    logic [1:0]   cfg_idx;
    logic [3:0]   cfg_weight;
    logic [1:0]   state_o;
    logic [31:0]  beat_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0=idle, 1=run, 2=reload
    int          m_state;
    int          m_ptr;
    int          m_w [4];
    int          m_c [4];
    logic [31:0] m_cnt;

    mpfifo_write_scheduler #(
        .DATA_WIDTH      (32),
        .N_REQ           (4),
        .NUM_WRITE_PORTS (2),
        .WEIGHT_W        (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_wr_ready (fifo_wr_ready),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_weight    (cfg_weight),
        .state_o       (state_o),
        .beat_count    (beat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_cnt   = '0;
        for (int i = 0; i < 4; i++) begin
            m_w[i] = 1;
            m_c[i] = 0;
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance both.
    task automatic cycle(input logic rn, input logic en, input logic [3:0] v,
                         input logic [1:0] rdy, input logic we,
                         input logic [1:0] idx, input logic [3:0] w);
        int          s;
        int          ngr;
        int          q[$];
        logic [3:0]  exp_ready;
        logic [1:0]  exp_en;
        logic [63:0] exp_data;
        logic        weighted;
        @(negedge clk);
        rst_n = rn; enable = en; req_valid = v; fifo_wr_ready = rdy;
        cfg_we = we; cfg_idx = idx; cfg_weight = w;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = $urandom;
        #1;
        s = 0;
        for (int p = 0; p < 2; p++) if (rdy[p] && s == p) s++;
        weighted = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (v[i] && m_w[i] != 0 && m_c[i] != 0) q.push_back(i);
            if (v[k] && m_w[k] != 0) weighted = 1'b1;
        end
        ngr = (m_state == 1) ? ((s < q.size()) ? s : q.size()) : 0;
        exp_ready = '0; exp_en = '0; exp_data = '0;
        for (int p = 0; p < ngr; p++) begin
            exp_ready[q[p]]      = 1'b1;
            exp_en[p]            = 1'b1;
            exp_data[p*32 +: 32] = req_data[q[p]*32 +: 32];
        end
        check("state", 64'(state_o), 64'(m_state));
        check("beat_count", 64'(beat_count), 64'(m_cnt));
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("fifo_wr_en", 64'(fifo_wr_en), 64'(exp_en));
        check("fifo_wr_data", fifo_wr_data, exp_data);
        if (!rn) begin
            model_reset();
        end else begin
            case (m_state)
                0: if (en) begin m_state = 1; m_c = m_w; end
                1: begin
                    for (int p = 0; p < ngr; p++) m_c[q[p]]--;
                    if (ngr > 0) m_ptr = (q[ngr-1] + 1) % 4;
                    m_cnt = m_cnt + 32'(ngr);
                    if (!en) m_state = 0;
                    else if (weighted && q.size() == 0) m_state = 2;
                end
                default: begin m_c = m_w; m_state = en ? 1 : 0; end
            endcase
            if (we) m_w[idx] = int'(w);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; req_valid = '0; req_data = '0;
        fifo_wr_ready = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_count", 64'(beat_count), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_en", 64'(fifo_wr_en), 64'd0);
        check("rst_data", fifo_wr_data, 64'd0);

        // Full-rate round robin through a credit reload
        repeat (6) cycle(1, 1, 4'hF, 2'b11, 0, 0, 0);
        check("t1_beats", 64'(beat_count), 64'd6);

        // Single port, then a non-thermometer ready pattern
        cycle(0, 0, 4'h0, 2'b00, 0, 0, 0);
        repeat (10) cycle(1, 1, 4'hF, 2'b01, 0, 0, 0);
        repeat (3) cycle(1, 1, 4'hF, 2'b10, 0, 0, 0);
        check("t2_en_zero", 64'(fifo_wr_en), 64'd0);

        // Heavier weight on requester 0, reset part-way through
        cycle(0, 0, 4'h0, 2'b00, 0, 0, 0);
        cycle(1, 0, 4'h0, 2'b00, 1, 2'd0, 4'd3);
        repeat (7) cycle(1, 1, 4'hF, 2'b11, 0, 0, 0);
        check("t3_beats", 64'(beat_count), 64'd6);
        cycle(0, 1, 4'hF, 2'b11, 0, 0, 0);
        check("t6_state", 64'(state_o), 64'd0);
        check("t6_count", 64'(beat_count), 64'd0);
        check("t6_ready", 64'(req_ready), 64'd0);
        repeat (5) cycle(1, 1, 4'hF, 2'b11, 0, 0, 0);

        // Enable dropped after first grant cycle, then resumed
        cycle(0, 0, 4'h0, 2'b00, 0, 0, 0);
        cycle(1, 1, 4'hF, 2'b11, 0, 0, 0);
        cycle(1, 0, 4'hF, 2'b11, 0, 0, 0);
        cycle(1, 0, 4'hF, 2'b11, 0, 0, 0);
        check("t4_idle", 64'(state_o), 64'd0);
        check("t4_count", 64'(beat_count), 64'd2);
        repeat (2) cycle(1, 1, 4'hF, 2'b11, 0, 0, 0);
        check("t4_resume", 64'(beat_count), 64'd4);

        // Zero-weight requester alone never granted, never reloads
        cycle(0, 0, 4'h0, 2'b00, 0, 0, 0);
        cycle(1, 0, 4'h0, 2'b00, 1, 2'd1, 4'd0);
        repeat (11) cycle(1, 1, 4'h2, 2'b11, 0, 0, 0);
        check("t5_state", 64'(state_o), 64'd1);
        check("t5_count", 64'(beat_count), 64'd0);

        // Random traffic, configuration and occasional resets
        repeat (600) begin
            logic [3:0] wt;
            wt = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) != 0),
                  4'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0),
                  2'($urandom), wt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
